// File: rtl/serial_fifo_ctrl_if.sv
// Bus bundle between devctrl, the UART pair and serial_fifo_ctrl.
// master: devctrl/UART side (drives strobes, rx bytes, busy); slave: the controller.
// Ports: CPU access strobe/data, COM interrupt, rx byte pulse, tx start/data/busy.
interface serial_fifo_ctrl_if;
    // CPU access side (devctrl com* strobes)
    logic        enable_i;
    logic        readEnable_i;
    logic        mode_i;
    logic [31:0] dataSave_i;
    logic [31:0] dataLoad_o;
    logic        int_o;
    // async_receiver side
    logic        rxdReady_i;
    logic [7:0]  rxdData_i;
    // async_transmitter side
    logic        txdBusy_i;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    modport master (
        output enable_i, readEnable_i, mode_i, dataSave_i,
        output rxdReady_i, rxdData_i, txdBusy_i,
        input  dataLoad_o, int_o, txdStart_o, txdData_o
    );

    modport slave (
        input  enable_i, readEnable_i, mode_i, dataSave_i,
        input  rxdReady_i, rxdData_i, txdBusy_i,
        output dataLoad_o, int_o, txdStart_o, txdData_o
    );
endinterface

// File: rtl/serial_fifo_ctrl.sv
// Buffered COM-port controller: RX FIFO from async_receiver, TX FIFO drained into async_transmitter.
// Latency: reads combinational in the strobe cycle; int_o registered one cycle after RX occupancy changes.
// Backpressure: none upstream; RX bytes into a full FIFO are dropped (sticky ovr), CPU writes into a full TX FIFO are dropped.
//
// Ports (bundled in serial_fifo_ctrl_if.slave, plus clk25 and synchronous active-high rst):
//   enable_i/readEnable_i/mode_i/dataSave_i -> CPU access, dataLoad_o read data, int_o COM interrupt
//   rxdReady_i/rxdData_i -> received byte pulse, txdBusy_i/txdStart_o/txdData_o -> transmitter handshake
// Optional build macro SERIAL_LOOPBACK_EN: adds the lpbk control bit (STATUS bit1 write, bit4 read)
// that routes TX bytes straight back into the RX FIFO instead of the transmitter.
module serial_fifo_ctrl #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic               clk25,
    input  logic               rst,
    serial_fifo_ctrl_if.slave  bus
);

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_PTR_ONE = 1;
    localparam logic [TX_AW:0] TX_PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr;
    logic [RX_AW:0] rx_rd_ptr;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr;
    logic [TX_AW:0] tx_rd_ptr;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     wait_cnt;
    logic [1:0]     wait_cnt_nxt;
    logic [7:0]     txd_dat;
    logic           ovr;
    logic           rx_int_en;
    logic           int_q;
    logic           lpbk;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic       rx_empty;
    logic       rx_full;
    logic [7:0] rx_head;
    logic       tx_empty;
    logic       tx_full;
    logic [7:0] tx_head;

    // Pointers carry one extra wrap bit: equal -> empty, only the wrap bit differs -> full.
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
    assign rx_head  = rx_mem[rx_rd_ptr[RX_AW-1:0]];

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign tx_head  = tx_mem[tx_rd_ptr[TX_AW-1:0]];

    // ------------------------------------------------------------------
    // CPU access decode. Accesses in the reset cycle are ignored entirely
    // so a read there has no pop/clear side effect and returns 0.
    // ------------------------------------------------------------------
    logic cpu_rd;
    logic cpu_wr;
    logic data_rd;
    logic stat_rd;
    logic data_wr;
    logic stat_wr;

    assign cpu_rd  = bus.enable_i &&  bus.readEnable_i && !rst;
    assign cpu_wr  = bus.enable_i && !bus.readEnable_i && !rst;
    assign data_rd = cpu_rd && !bus.mode_i;
    assign stat_rd = cpu_rd &&  bus.mode_i;
    assign data_wr = cpu_wr && !bus.mode_i;
    assign stat_wr = cpu_wr &&  bus.mode_i;

    // ------------------------------------------------------------------
    // Drain FSM (next state / outputs)
    // ------------------------------------------------------------------
    logic tx_pop;
    logic load_txd;
    logic lb_move;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        tx_pop       = 1'b0;
        load_txd     = 1'b0;
        lb_move      = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    if (lpbk) begin
                        // Loopback: byte moves TX head -> RX tail in one cycle, transmitter untouched.
                        tx_pop  = 1'b1;
                        lb_move = 1'b1;
                    end else if (!bus.txdBusy_i) begin
                        tx_pop    = 1'b1;
                        load_txd  = 1'b1;
                        state_nxt = START;
                    end
                end
            end
            START: begin
                wait_cnt_nxt = 2'd0;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never raises busy is treated as done after
                // three cycles so the queue cannot stall forever.
                if (bus.txdBusy_i) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == 2'd2) begin
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.txdBusy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO push/pop qualification
    // ------------------------------------------------------------------
    logic       rx_push_req;
    logic [7:0] rx_push_dat;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_drop;
    logic       tx_push;

    // In loopback the receiver is ignored; the drain FSM is the only RX source.
    assign rx_push_req = lpbk ? lb_move : bus.rxdReady_i;
    assign rx_push_dat = lpbk ? tx_head : bus.rxdData_i;

    assign rx_pop  = data_rd && !rx_empty;
    // A pop in the same cycle frees the slot being written, so full+pop still accepts.
    assign rx_push = rx_push_req && (!rx_full || rx_pop);
    assign rx_drop = rx_push_req &&   rx_full && !rx_pop;
    assign tx_push = data_wr && (!tx_full || tx_pop);

    // ------------------------------------------------------------------
    // Storage arrays (no reset: contents are qualified by the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk25) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_push_dat;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= bus.dataSave_i[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk25) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            state     <= IDLE;
            wait_cnt  <= 2'd0;
            txd_dat   <= 8'h00;
            ovr       <= 1'b0;
            rx_int_en <= 1'b1;
            int_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;

            if (load_txd) txd_dat <= tx_head;

            // A drop in the same cycle as a STATUS read must not be lost,
            // so setting wins over the read-clear.
            if (rx_drop) begin
                ovr <= 1'b1;
            end else if (stat_rd) begin
                ovr <= 1'b0;
            end

            if (stat_wr) rx_int_en <= bus.dataSave_i[0];

            int_q <= rx_int_en && !rx_empty;
        end
    end

`ifdef SERIAL_LOOPBACK_EN
    always_ff @(posedge clk25) begin
        if (rst) begin
            lpbk <= 1'b0;
        end else if (stat_wr) begin
            lpbk <= bus.dataSave_i[1];
        end
    end
`else
    assign lpbk = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic        tx_idle;
    logic [31:0] stat_word;

    assign tx_idle   = tx_empty && (state == IDLE) && !bus.txdBusy_i;
    assign stat_word = {27'h0, lpbk, tx_idle, ovr, !rx_empty, !tx_full};

    always_comb begin
        bus.dataLoad_o = 32'h0;
        if (data_rd) begin
            bus.dataLoad_o = rx_empty ? 32'h0 : {24'h0, rx_head};
        end else if (stat_rd) begin
            bus.dataLoad_o = stat_word;
        end
    end

    // Gated with rst so a reset arriving in START suppresses the pulse immediately.
    assign bus.txdStart_o = (state == START) && !rst;
    assign bus.txdData_o  = txd_dat;
    assign bus.int_o      = int_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Directed bench for serial_fifo_ctrl with RX/TX scoreboards and a transmitter model.
// Clock 25 MHz (40 ns); inputs driven at negedge, outputs sampled 2 ns after negedge or 1 ns after posedge.
// Transmitter model raises busy two cycles after each start (optionally never, to exercise the timeout).
module tb_serial_fifo_ctrl;

    logic clk25 = 1'b0;
    logic rst   = 1'b1;

    always #20 clk25 = ~clk25;

    serial_fifo_ctrl_if bus ();

    serial_fifo_ctrl #(
        .RX_AW (4),
        .TX_AW (4)
    ) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];

    int   n_starts = 0;
    int   busy_len = 20;
    int   dly      = 0;
    int   bcnt     = 0;
    logic silent   = 1'b0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Transmitter model and TX scoreboard.
    initial begin
        bus.txdBusy_i = 1'b0;
        forever begin
            @(negedge clk25);
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) bus.txdBusy_i = 1'b0;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0 && !silent) begin
                    bus.txdBusy_i = 1'b1;
                    bcnt = busy_len;
                end
            end
            if (bus.txdStart_o === 1'b1) begin
                n_starts++;
                chk("start_while_busy", 32'(bus.txdBusy_i), 32'h0);
                chk("start_expected", 32'(tx_q.size() != 0), 32'h1);
                if (tx_q.size() != 0) begin
                    chk("txd_data", {24'h0, bus.txdData_o}, {24'h0, tx_q.pop_front()});
                end
                dly = 2;
            end
        end
    end

    task automatic cpu_rd(input logic m, output logic [31:0] d);
        @(negedge clk25);
        bus.enable_i     = 1'b1;
        bus.readEnable_i = 1'b1;
        bus.mode_i       = m;
        #2;
        d = bus.dataLoad_o;
        @(posedge clk25);
        #1;
        bus.enable_i     = 1'b0;
        bus.readEnable_i = 1'b0;
    endtask

    task automatic cpu_wr(input logic m, input logic [31:0] v);
        @(negedge clk25);
        bus.enable_i     = 1'b1;
        bus.readEnable_i = 1'b0;
        bus.mode_i       = m;
        bus.dataSave_i   = v;
        @(posedge clk25);
        #1;
        bus.enable_i     = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk25);
        bus.rxdReady_i = 1'b1;
        bus.rxdData_i  = b;
        if (rx_q.size() < 16) rx_q.push_back(b);
        @(posedge clk25);
        #1;
        bus.rxdReady_i = 1'b0;
    endtask

    task automatic rd_data_chk(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        cpu_rd(1'b0, d);
        e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        chk(tag, d, e);
    endtask

    task automatic rd_stat_chk(input string tag, input logic [31:0] e);
        logic [31:0] d;
        cpu_rd(1'b1, d);
        chk(tag, d, e);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk25);
        #1;
    endtask

    task automatic wait_tx_drain(input string tag, input int budget);
        int i;
        i = 0;
        while ((tx_q.size() != 0 || bus.txdBusy_i || dly != 0) && i < budget) begin
            @(negedge clk25);
            i++;
        end
        chk(tag, 32'(i < budget), 32'h1);
        cycles(6);
    endtask

    initial begin
        logic [31:0] d;
        int          s0;
        int          i;

        bus.enable_i     = 1'b0;
        bus.readEnable_i = 1'b0;
        bus.mode_i       = 1'b0;
        bus.dataSave_i   = 32'h0;
        bus.rxdReady_i   = 1'b0;
        bus.rxdData_i    = 8'h00;

        // 1. Reset state
        cycles(3);
        @(negedge clk25);
        rst = 1'b0;
        #2;
        chk("reset_int", 32'(bus.int_o), 32'h0);
        chk("reset_start", 32'(bus.txdStart_o), 32'h0);
        chk("reset_txd_data", {24'h0, bus.txdData_o}, 32'h0);
        chk("idle_dataload", bus.dataLoad_o, 32'h0);
        rd_stat_chk("reset_status", 32'h9);

        // 2. Two RX bytes, interrupt, reads, empty read
        rx_push(8'h41);
        rx_push(8'h42);
        chk("int_after_push", 32'(bus.int_o), 32'h1);
        rd_data_chk("rx_data_41");
        rd_data_chk("rx_data_42");
        cycles(1);
        chk("int_after_drain", 32'(bus.int_o), 32'h0);
        rd_data_chk("rx_empty_read");

        // 3. Overrun: 17 bytes into a 16-deep FIFO
        for (int k = 0; k < 17; k++) rx_push(8'(k));
        rd_stat_chk("status_ovr_set", 32'hF);
        rd_stat_chk("status_ovr_clear", 32'hB);
        for (int k = 0; k < 16; k++) rd_data_chk("rx_ovr_data");
        rd_data_chk("rx_after_ovr_empty");
        rd_stat_chk("status_after_ovr", 32'h9);

        // 4. TX drain through the transmitter model
        s0 = n_starts;
        busy_len = 20;
        cpu_wr(1'b0, 32'h55); tx_q.push_back(8'h55);
        cpu_wr(1'b0, 32'hAA); tx_q.push_back(8'hAA);
        cpu_wr(1'b0, 32'h0D); tx_q.push_back(8'h0D);
        wait_tx_drain("tx_drain_done", 300);
        chk("tx_start_count", 32'(n_starts - s0), 32'd3);
        rd_stat_chk("status_tx_idle", 32'h9);

        // 4b. Transmitter that never reports busy: FSM must time out and continue
        s0 = n_starts;
        silent = 1'b1;
        cpu_wr(1'b0, 32'h5A); tx_q.push_back(8'h5A);
        cpu_wr(1'b0, 32'hA5); tx_q.push_back(8'hA5);
        wait_tx_drain("tx_timeout_drain", 100);
        chk("tx_timeout_starts", 32'(n_starts - s0), 32'd2);
        silent = 1'b0;

        // 5. Full RX FIFO with push and pop in the same cycle
        for (int k = 0; k < 16; k++) rx_push(8'h80 + 8'(k));
        @(negedge clk25);
        bus.rxdReady_i   = 1'b1;
        bus.rxdData_i    = 8'hC0;
        bus.enable_i     = 1'b1;
        bus.readEnable_i = 1'b1;
        bus.mode_i       = 1'b0;
        #2;
        chk("full_pushpop_data", bus.dataLoad_o, {24'h0, rx_q.pop_front()});
        rx_q.push_back(8'hC0);
        @(posedge clk25);
        #1;
        bus.rxdReady_i   = 1'b0;
        bus.enable_i     = 1'b0;
        bus.readEnable_i = 1'b0;
        rd_stat_chk("full_pushpop_no_ovr", 32'hB);
        cpu_wr(1'b1, 32'h0);
        cycles(2);
        chk("int_masked", 32'(bus.int_o), 32'h0);
        for (int k = 0; k < 16; k++) rd_data_chk("rx_full_drain");
        rd_stat_chk("status_full_drained", 32'h9);

        // 6. Reset during WAIT_DONE with TX bytes queued
        rx_push(8'h66);
        for (int k = 0; k < 5; k++) begin
            cpu_wr(1'b0, 32'h10 + 32'(k));
            tx_q.push_back(8'h10 + 8'(k));
        end
        i = 0;
        while (bus.txdBusy_i !== 1'b1 && i < 100) begin
            @(negedge clk25);
            i++;
        end
        chk("busy_seen", 32'(i < 100), 32'h1);
        @(posedge clk25);
        @(negedge clk25);
        rst              = 1'b1;
        bus.enable_i     = 1'b1;
        bus.readEnable_i = 1'b1;
        bus.mode_i       = 1'b0;
        tx_q.delete();
        rx_q.delete();
        #2;
        chk("reset_cycle_read", bus.dataLoad_o, 32'h0);
        @(posedge clk25);
        #1;
        rst              = 1'b0;
        bus.enable_i     = 1'b0;
        bus.readEnable_i = 1'b0;
        s0 = n_starts;
        chk("midreset_start", 32'(bus.txdStart_o), 32'h0);
        chk("midreset_txd_data", {24'h0, bus.txdData_o}, 32'h0);
        cpu_rd(1'b1, d);
        chk("midreset_status", d, bus.txdBusy_i ? 32'h1 : 32'h9);
        wait_tx_drain("inflight_done", 100);
        cycles(10);
        chk("midreset_no_starts", 32'(n_starts - s0), 32'h0);
        rd_stat_chk("midreset_status_idle", 32'h9);
        rx_push(8'h77);
        cycles(1);
        chk("midreset_int_en", 32'(bus.int_o), 32'h1);
        rd_data_chk("midreset_rx_data");

`ifdef SERIAL_LOOPBACK_EN
        cpu_wr(1'b1, 32'h3);
        rd_stat_chk("lpbk_status", 32'h19);
        s0 = n_starts;
        cpu_wr(1'b0, 32'h33);
        rx_q.push_back(8'h33);
        cycles(3);
        rd_data_chk("lpbk_data");
        chk("lpbk_no_start", 32'(n_starts - s0), 32'h0);
`else
        cpu_wr(1'b1, 32'h3);
        rd_stat_chk("no_lpbk_status", 32'h9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
